reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/cpu_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 57 +++++
 rtl/reg_file.sv | 79 +++++++
 tb/tb_reg_file.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register-select width, register count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN           = 32;
    localparam int REG_SELECT_LEN = 5;
    localparam int NREGS          = 2 ** REG_SELECT_LEN;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_SELECT_LEN-1:0] reg_sel_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: issue reserves a destination, writeback releases it.
// Latency: busy_1/busy_2 registered, one edge after select, reflecting that edge's update.
// Backpressure: none; set/clear strobes are accepted every cycle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rsv_en / rsv_sel    reservation (sets a busy bit)
//   clr_en / clr_sel    writeback release (clears a busy bit)
//   rd_sel_1/2          lookup selects
//   busy_1/2            registered busy flags for the lookups
module reg_scoreboard #(
    parameter int REG_SELECT_LEN = cpu_pkg::REG_SELECT_LEN,
    parameter int NREGS          = cpu_pkg::NREGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rsv_en,
    input  logic [REG_SELECT_LEN-1:0] rsv_sel,
    input  logic                      clr_en,
    input  logic [REG_SELECT_LEN-1:0] clr_sel,
    input  logic [REG_SELECT_LEN-1:0] rd_sel_1,
    input  logic [REG_SELECT_LEN-1:0] rd_sel_2,
    output logic                      busy_1,
    output logic                      busy_2
);
    import cpu_pkg::*;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             busy_1_q, busy_1_d;
    logic             busy_2_q, busy_2_d;

    always_comb begin
        busy_d = busy_q;
        // Clear first so a same-index reservation in the same cycle wins.
        if (clr_en && (clr_sel != '0)) busy_d[clr_sel] = 1'b0;
        if (rsv_en && (rsv_sel != '0)) busy_d[rsv_sel] = 1'b1;
        // Lookups see the post-update state of this edge.
        busy_1_d = (rd_sel_1 == '0) ? 1'b0 : busy_d[rd_sel_1];
        busy_2_d = (rd_sel_2 == '0) ? 1'b0 : busy_d[rd_sel_2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_1_q <= 1'b0;
            busy_2_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            busy_1_q <= busy_1_d;
            busy_2_q <= busy_2_d;
        end
    end

    assign busy_1 = busy_1_q;
    assign busy_2 = busy_2_q;

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write architectural register file with x0 hardwired to zero and a busy scoreboard.
// Latency: reads registered, one edge; same-edge writes are bypassed into the read data.
// Backpressure: none; reads, writes and reservations are accepted every cycle.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   rd_sel_1/2             read selects -> rd_data_1/2, busy_1/2 (registered)
//   wr_en, wr_sel, wr_data writeback; wr_sel/wr_data are don't-care while wr_en=0
//   rsv_en, rsv_sel        issue-time reservation; rsv_sel is don't-care while rsv_en=0
module reg_file #(
    parameter int XLEN           = cpu_pkg::XLEN,
    parameter int REG_SELECT_LEN = cpu_pkg::REG_SELECT_LEN,
    parameter int NREGS          = cpu_pkg::NREGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_SELECT_LEN-1:0] rd_sel_1,
    output logic [XLEN-1:0]           rd_data_1,
    input  logic [REG_SELECT_LEN-1:0] rd_sel_2,
    output logic [XLEN-1:0]           rd_data_2,
    output logic                      busy_1,
    output logic                      busy_2,
    input  logic                      wr_en,
    input  logic [REG_SELECT_LEN-1:0] wr_sel,
    input  logic [XLEN-1:0]           wr_data,
    input  logic                      rsv_en,
    input  logic [REG_SELECT_LEN-1:0] rsv_sel
);
    import cpu_pkg::*;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] rd_data_1_q, rd_data_1_d;
    logic [XLEN-1:0] rd_data_2_q, rd_data_2_d;
    logic            wr_hit;

    // wr_en gates everything else, so an idle Z/X bus on wr_sel/wr_data is harmless.
    assign wr_hit = wr_en && (wr_sel != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[wr_sel] = wr_data;
        // Reading the next-state array gives the write-to-read bypass for free.
        rd_data_1_d = (rd_sel_1 == '0) ? '0 : regs_d[rd_sel_1];
        rd_data_2_d = (rd_sel_2 == '0) ? '0 : regs_d[rd_sel_2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            rd_data_1_q <= '0;
            rd_data_2_q <= '0;
        end else begin
            regs_q      <= regs_d;
            rd_data_1_q <= rd_data_1_d;
            rd_data_2_q <= rd_data_2_d;
        end
    end

    assign rd_data_1 = rd_data_1_q;
    assign rd_data_2 = rd_data_2_q;

    reg_scoreboard #(
        .REG_SELECT_LEN (REG_SELECT_LEN),
        .NREGS          (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .clr_en   (wr_en),
        .clr_sel  (wr_sel),
        .rd_sel_1 (rd_sel_1),
        .rd_sel_2 (rd_sel_2),
        .busy_1   (busy_1),
        .busy_2   (busy_2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against a behavioural array/bit-vector model.
// Latency: model expects read data and busy one edge after select.
// Backpressure: n/a.
module tb_reg_file;
    import cpu_pkg::*;

    logic     clk;
    logic     rst_n;
    reg_sel_t rd_sel_1, rd_sel_2, wr_sel, rsv_sel;
    word_t    rd_data_1, rd_data_2, wr_data;
    logic     busy_1, busy_2, wr_en, rsv_en;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    word_t mem_m  [NREGS];
    bit    busy_m [NREGS];
    word_t exp_rd1, exp_rd2;
    bit    exp_b1, exp_b2;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_sel_1  (rd_sel_1),
        .rd_data_1 (rd_data_1),
        .rd_sel_2  (rd_sel_2),
        .rd_data_2 (rd_data_2),
        .busy_1    (busy_1),
        .busy_2    (busy_2),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_sel   (rsv_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one clock edge to the model: a write becomes visible to reads at the
    // same edge, a reservation beats a release of the same register, x0 is always 0.
    task automatic model_edge();
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_m[i]  = '0;
                busy_m[i] = 1'b0;
            end
            exp_rd1 = '0; exp_rd2 = '0; exp_b1 = 1'b0; exp_b2 = 1'b0;
        end else begin
            if (wr_en === 1'b1 && wr_sel != 0) begin
                mem_m[wr_sel]  = wr_data;
                busy_m[wr_sel] = 1'b0;
            end
            if (rsv_en === 1'b1 && rsv_sel != 0) busy_m[rsv_sel] = 1'b1;
            exp_rd1 = (rd_sel_1 == 0) ? '0 : mem_m[rd_sel_1];
            exp_rd2 = (rd_sel_2 == 0) ? '0 : mem_m[rd_sel_2];
            exp_b1  = (rd_sel_1 == 0) ? 1'b0 : busy_m[rd_sel_1];
            exp_b2  = (rd_sel_2 == 0) ? 1'b0 : busy_m[rd_sel_2];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rsv_en = 1'b0;
        wr_sel = '0; wr_data = '0; rsv_sel = '0;
    endtask

    function automatic reg_sel_t rand_sel();
        if ($urandom_range(0, 1) == 1) return reg_sel_t'($urandom_range(0, 7));
        return reg_sel_t'($urandom_range(0, NREGS - 1));
    endfunction

    task automatic test_reset();
        idle_inputs();
        rd_sel_1 = 5'd5; rd_sel_2 = 5'd5;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_data_1 !== '0 || rd_data_2 !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rd1=%h rd2=%h, required 0", rd_data_1, rd_data_2);
        end
        vectors++;
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: b1=%b b2=%b, required 0", busy_1, busy_2);
        end
        step(); step();
        #2 rst_n = 1'b1;
        step();
        vectors++;
        if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL read_x5_after_reset: rd1=%h rd2=%h, required 0", rd_data_1, rd_data_2);
        end
        vectors++;
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_x5_after_reset: b1=%b b2=%b, required 0", busy_1, busy_2);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_sel = 5'd7; wr_data = 32'hDEADBEEF;
        rd_sel_1 = 5'd1;
        step();
        idle_inputs();
        rd_sel_1 = 5'd7;
        step();
        vectors++;
        if (rd_data_1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write_read_x7: got %h, required deadbeef", rd_data_1);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_sel = 5'd3; wr_data = 32'h12345678;
        rd_sel_2 = 5'd3;
        step();
        idle_inputs();
        vectors++;
        if (rd_data_2 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bypass_x3: got %h, required 12345678", rd_data_2);
        end
    endtask

    task automatic test_x0();
        wr_en = 1'b1; wr_sel = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_sel_1 = 5'd0; rd_sel_2 = 5'd0;
        rsv_en = 1'b1; rsv_sel = 5'd0;
        step();
        vectors++;
        if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_bypass: rd1=%h rd2=%h, required 0", rd_data_1, rd_data_2);
        end
        idle_inputs();
        step();
        vectors++;
        if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_read: rd1=%h rd2=%h, required 0", rd_data_1, rd_data_2);
        end
        vectors++;
        if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_busy: b1=%b b2=%b, required 0", busy_1, busy_2);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_sel = 5'd9; rd_sel_1 = 5'd9;
        step();
        vectors++;
        if (busy_1 !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_same_cycle: busy_1=%b, required 1", busy_1);
        end
        wr_en = 1'b1; wr_sel = 5'd9; wr_data = 32'hA5A5_0009;
        step();
        vectors++;
        if (busy_1 !== 1'b1) begin
            miscompares++;
            $display("FAIL set_clear_same_idx: busy_1=%b, required 1", busy_1);
        end
        rsv_en = 1'b0;
        step();
        vectors++;
        if (busy_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_x9: busy_1=%b, required 0", busy_1);
        end
        idle_inputs();
        rsv_en = 1'b1; rsv_sel = 5'd11;
        step();
        rsv_sel = 5'd12; wr_en = 1'b1; wr_sel = 5'd11; wr_data = 32'h0000_0011;
        rd_sel_1 = 5'd11; rd_sel_2 = 5'd12;
        step();
        idle_inputs();
        vectors++;
        if (busy_1 !== 1'b0 || busy_2 !== 1'b1) begin
            miscompares++;
            $display("FAIL set_clear_diff_idx: b1=%b b2=%b, required 0 1", busy_1, busy_2);
        end
    endtask

    task automatic test_idle_z();
        wr_en = 1'b0; wr_sel = 'z; wr_data = 'z;
        rsv_en = 1'b0; rsv_sel = 'z;
        for (int i = 0; i < 10; i++) begin
            rd_sel_1 = rand_sel(); rd_sel_2 = rand_sel();
            step();
            vectors++;
            if (rd_data_1 !== exp_rd1 || rd_data_2 !== exp_rd2 ||
                busy_1 !== exp_b1 || busy_2 !== exp_b2) begin
                miscompares++;
                $display("FAIL idle_z[%0d]: rd=%h/%h busy=%b/%b, required %h/%h %b/%b",
                         i, rd_data_1, rd_data_2, busy_1, busy_2, exp_rd1, exp_rd2, exp_b1, exp_b2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_sel   = rand_sel();
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 1) == 1);
            rsv_sel  = rand_sel();
            rd_sel_1 = rand_sel();
            rd_sel_2 = ($urandom_range(0, 3) == 0) ? rd_sel_1 : rand_sel();
            step();
            vectors++;
            if (rd_data_1 !== exp_rd1 || rd_data_2 !== exp_rd2) begin
                miscompares++;
                $display("FAIL random_data[%0d]: rd=%h/%h, required %h/%h",
                         i, rd_data_1, rd_data_2, exp_rd1, exp_rd2);
            end
            vectors++;
            if (busy_1 !== exp_b1 || busy_2 !== exp_b2) begin
                miscompares++;
                $display("FAIL random_busy[%0d]: busy=%b/%b, required %b/%b",
                         i, busy_1, busy_2, exp_b1, exp_b2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        for (int r = 1; r <= 2; r++) begin
            wr_en = 1'b1; wr_sel = reg_sel_t'(r); wr_data = 32'hC0DE_0000 + r;
            rsv_en = 1'b1; rsv_sel = reg_sel_t'(r + 20);
            step();
        end
        wr_sel = 5'd3; wr_data = 32'hC0DE_0003;
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_data_1 !== '0 || rd_data_2 !== '0 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: rd=%h/%h busy=%b/%b, required 0",
                     rd_data_1, rd_data_2, busy_1, busy_2);
        end
        step();
        wr_sel = 5'd4; wr_data = 32'hC0DE_0004;
        step();
        #2 rst_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < NREGS; i++) begin
            rd_sel_1 = reg_sel_t'(i);
            rd_sel_2 = reg_sel_t'(i + 20);
            step();
            vectors++;
            if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_x%0d: rd=%h/%h busy=%b/%b, required 0",
                         i, rd_data_1, rd_data_2, busy_1, busy_2);
            end
        end
    endtask

    initial begin
        rd_sel_1 = '0; rd_sel_2 = '0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_idle_z();
        test_random();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
